// File: rtl/ifetch_if.sv
// ============================================================================
// Module   : ifetch_if
// Brief    : Instruction-memory read bus between ifetch and instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_resp,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
// Module   : ifetch
// Brief    : LC-3b instruction fetch unit; owns the PC, reads instruction
//            memory and hands each word to the IR with a one-cycle load pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        fetch_req,
    input  wire logic        pc_load,
    input  wire logic [15:0] pc_in,
    ifetch_if.master         mem,
    output logic      [15:0] ir_word,
    output logic             load_ir,
    output logic      [15:0] pc_out,
    output logic             busy
);

    localparam logic [15:0] c_PC_START = RESET_PC & 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [15:0] r_addr;
    logic [15:0] r_ir;
    logic        r_squash;
    logic        w_mem_read;
    logic        w_load_ir;
    logic        w_busy;
    logic [15:0] w_target;

    assign w_target = pc_in & 16'hFFFE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Strobes decode straight from the state so reset drops them immediately.
    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        w_load_ir    = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (fetch_req) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                w_mem_read = 1'b1;
                if (mem.mem_resp) begin
                    w_next_state = (r_squash || pc_load) ? GAP : DELIVER;
                end
            end
            DELIVER: begin
                w_load_ir    = 1'b1;
                w_next_state = IDLE;
            end
            GAP: begin
                w_next_state = REQ;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= c_PC_START;
            r_addr   <= c_PC_START;
            r_ir     <= 16'h0000;
            r_squash <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pc_load) begin
                        r_pc <= w_target;
                    end
                    if (fetch_req) begin
                        r_addr <= pc_load ? w_target : r_pc;
                    end
                end
                REQ: begin
                    if (mem.mem_resp) begin
                        if (r_squash || pc_load) begin
                            // Stale word: drop it, PC already holds (or now takes) the redirect.
                            r_squash <= 1'b0;
                            if (pc_load) begin
                                r_pc <= w_target;
                            end
                        end else begin
                            r_ir <= mem.mem_rdata;
                            r_pc <= r_addr + 16'd2;
                        end
                    end else if (pc_load) begin
                        r_squash <= 1'b1;
                        r_pc     <= w_target;
                    end
                end
                DELIVER: begin
                    if (pc_load) begin
                        r_pc <= w_target;
                    end
                end
                GAP: begin
                    r_addr <= pc_load ? w_target : r_pc;
                    if (pc_load) begin
                        r_pc <= w_target;
                    end
                end
                default: begin
                    r_squash <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_read    = w_mem_read;
    assign mem.mem_address = r_addr;
    assign load_ir         = w_load_ir;
    assign busy            = w_busy;
    assign ir_word         = r_ir;
    assign pc_out          = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module   : tb_ifetch
// Brief    : Self-checking bench for ifetch: directed scenarios plus random
//            traffic compared each cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;

    logic [15:0] ir0, pc0, ir1, pc1;
    logic        ld0, busy0, ld1, busy1;

    ifetch_if mif0 ();
    ifetch_if mif1 ();

    assign mif0.mem_resp  = mem_resp;
    assign mif0.mem_rdata = mem_rdata;
    assign mif1.mem_resp  = mem_resp;
    assign mif1.mem_rdata = mem_rdata;

    ifetch #(.RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .reset     (rst),
        .fetch_req (fetch_req),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .mem       (mif0.master),
        .ir_word   (ir0),
        .load_ir   (ld0),
        .pc_out    (pc0),
        .busy      (busy0)
    );

    // Control flow is PC-independent, so this copy runs in lockstep.
    ifetch #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk       (clk),
        .reset     (rst),
        .fetch_req (fetch_req),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .mem       (mif1.master),
        .ir_word   (ir1),
        .load_ir   (ld1),
        .pc_out    (pc1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    // Transaction-level model: a fetch is either outstanding, being handed
    // over, or waiting one idle cycle after a discarded response.
    bit          m_inflight, m_deliver, m_gap, m_squash;
    logic [15:0] m_addr, m_pc, m_ir;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0; m_deliver = 0; m_gap = 0; m_squash = 0;
        m_addr = 16'h0000; m_pc = 16'h0000; m_ir = 16'h0000;
    endtask

    task automatic model_step(input bit fr, input bit pl, input logic [15:0] pin,
                              input bit resp, input logic [15:0] rd);
        logic [15:0] tgt;
        tgt = {pin[15:1], 1'b0};
        if (m_deliver) begin
            m_deliver = 0;
            if (pl) m_pc = tgt;
        end else if (m_gap) begin
            m_gap      = 0;
            m_inflight = 1;
            m_addr     = pl ? tgt : m_pc;
            if (pl) m_pc = tgt;
        end else if (m_inflight) begin
            if (resp) begin
                m_inflight = 0;
                if (m_squash || pl) begin
                    if (pl) m_pc = tgt;
                    m_squash = 0;
                    m_gap    = 1;
                end else begin
                    m_ir      = rd;
                    m_pc      = 16'((32'(m_addr) + 2) % 65536);
                    m_deliver = 1;
                end
            end else if (pl) begin
                m_squash = 1;
                m_pc     = tgt;
            end
        end else begin
            if (fr) begin
                m_inflight = 1;
                m_addr     = pl ? tgt : m_pc;
            end
            if (pl) m_pc = tgt;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_read",    {15'b0, mif0.mem_read}, {15'b0, m_inflight});
            chk("mem_address", mif0.mem_address, m_addr);
            chk("load_ir",     {15'b0, ld0}, {15'b0, m_deliver});
            chk("busy",        {15'b0, busy0}, {15'b0, m_inflight | m_deliver | m_gap});
            chk("ir_word",     ir0, m_ir);
            chk("pc_out",      pc0, m_pc);
            chk("wrap_lockstep_read", {15'b0, mif1.mem_read}, {15'b0, m_inflight});
        end
    end

    task automatic cyc(input bit fr, input bit pl, input logic [15:0] pin,
                       input bit resp, input logic [15:0] rd);
        fetch_req = fr; pc_load = pl; pc_in = pin; mem_resp = resp; mem_rdata = rd;
        @(posedge clk);
        #1;
        cyc_n++;
        model_step(fr, pl, pin, resp, rd);
        fetch_req = 0; pc_load = 0; mem_resp = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 16'h0000, 0, 16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    int  t_prev, t_now, wait_n, waited;
    bit  r_fr, r_pl, r_resp, was_inflight;
    logic [15:0] r_pin, r_rd;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic fetch, two wait states.
        cyc(1, 0, 16'h0000, 0, 16'h0000);
        chk("basic_read_c1", {15'b0, mif0.mem_read}, 16'h0001);
        chk("basic_addr", mif0.mem_address, 16'h0000);
        idle();
        chk("basic_read_c2", {15'b0, mif0.mem_read}, 16'h0001);
        idle();
        chk("basic_read_c3", {15'b0, mif0.mem_read}, 16'h0001);
        cyc(0, 0, 16'h0000, 1, 16'h1283);
        chk("basic_load_ir", {15'b0, ld0}, 16'h0001);
        chk("basic_ir_word", ir0, 16'h1283);
        chk("basic_pc_out", pc0, 16'h0002);
        idle();
        chk("basic_load_ir_off", {15'b0, ld0}, 16'h0000);
        chk("basic_busy_off", {15'b0, busy0}, 16'h0000);

        // Back-to-back, zero wait.
        do_reset();
        t_prev = -1;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 16'h0000, 0, 16'h0000);
            chk("b2b_addr", mif0.mem_address, 16'(2 * k));
            cyc(0, 0, 16'h0000, 1, 16'(16'hA000 + k));
            chk("b2b_load_ir", {15'b0, ld0}, 16'h0001);
            t_now = cyc_n;
            if (t_prev >= 0) chk("b2b_interval", 16'(t_now - t_prev), 16'd3);
            t_prev = t_now;
            cyc(1, 0, 16'h0000, 0, 16'h0000);
            chk("b2b_read_low", {15'b0, mif0.mem_read}, 16'h0000);
        end

        // Redirect in first REQ cycle, response after 3 cycles.
        do_reset();
        cyc(1, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 1, 16'h3000, 0, 16'h0000);
        chk("squash_addr_hold", mif0.mem_address, 16'h0000);
        idle();
        cyc(0, 0, 16'h0000, 1, 16'hDEAD);
        chk("squash_gap_read", {15'b0, mif0.mem_read}, 16'h0000);
        chk("squash_no_load", {15'b0, ld0}, 16'h0000);
        chk("squash_ir_kept", ir0, 16'h0000);
        idle();
        chk("squash_new_addr", mif0.mem_address, 16'h3000);
        cyc(0, 0, 16'h0000, 1, 16'h4321);
        chk("squash_pc_out", pc0, 16'h3002);
        chk("squash_ir_word", ir0, 16'h4321);

        // Redirect coincident with response, then in DELIVER, then with fetch_req.
        do_reset();
        cyc(1, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 1, 16'h0100, 1, 16'hBEEF);
        chk("coll_no_load", {15'b0, ld0}, 16'h0000);
        chk("coll_pc", pc0, 16'h0100);
        idle();
        chk("coll_refetch", mif0.mem_address, 16'h0100);
        cyc(0, 0, 16'h0000, 1, 16'h5555);
        chk("deliv_load", {15'b0, ld0}, 16'h0001);
        cyc(0, 1, 16'h0200, 0, 16'h0000);
        chk("deliv_redirect_pc", pc0, 16'h0200);
        chk("deliv_ir", ir0, 16'h5555);
        cyc(1, 1, 16'h0041, 0, 16'h0000);
        chk("idle_redirect_addr", mif0.mem_address, 16'h0040);
        cyc(0, 0, 16'h0000, 1, 16'h0777);
        chk("idle_redirect_pc", pc0, 16'h0042);

        // Wrap at the top of the address space.
        do_reset();
        cyc(1, 0, 16'h0000, 0, 16'h0000);
        chk("wrap_addr", mif1.mem_address, 16'hFFFE);
        cyc(0, 0, 16'h0000, 1, 16'h1111);
        chk("wrap_pc", pc1, 16'h0000);
        chk("wrap_load", {15'b0, ld1}, 16'h0001);
        idle();
        cyc(1, 1, 16'hFFFF, 0, 16'h0000);
        chk("wrap_redirect_addr", mif0.mem_address, 16'hFFFE);
        cyc(0, 0, 16'h0000, 1, 16'h2222);
        chk("wrap_redirect_pc", pc0, 16'h0000);
        idle();

        // Reset while a request is outstanding.
        cyc(1, 0, 16'h0000, 0, 16'h0000);
        chk("rst_pre_read", {15'b0, mif0.mem_read}, 16'h0001);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_read", {15'b0, mif0.mem_read}, 16'h0000);
        chk("rst_busy", {15'b0, busy0}, 16'h0000);
        chk("rst_load", {15'b0, ld0}, 16'h0000);
        chk("rst_pc", pc0, 16'h0000);
        chk("rst_ir", ir0, 16'h0000);
        chk("rst_wrap_pc", pc1, 16'hFFFE);
        #1;
        rst = 1'b0;
        cyc(1, 0, 16'h0000, 0, 16'h0000);
        chk("rst_refetch", mif0.mem_address, 16'h0000);
        cyc(0, 0, 16'h0000, 1, 16'h0abc);
        idle();

        // Random traffic with variable memory latency.
        wait_n = 0;
        waited = 0;
        repeat (4000) begin
            r_fr   = ($urandom % 3) == 0;
            r_pl   = ($urandom % 7) == 0;
            r_pin  = 16'($urandom);
            r_rd   = 16'($urandom);
            r_resp = m_inflight && (waited >= wait_n);
            was_inflight = m_inflight;
            cyc(r_fr, r_pl, r_pin, r_resp, r_rd);
            if (m_inflight && !was_inflight) begin
                waited = 0;
                wait_n = int'($urandom % 4);
            end else if (m_inflight) begin
                waited++;
            end
            if (($urandom % 400) == 0) begin
                do_reset();
                waited = 0;
            end
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the LC-3b datapath: the producer side of the instruction register's `load`/`in` interface. It owns the PC and issues word reads to instruction memory using the hold-until-`mem_resp` protocol. It presents each fetched word on `ir_word` with a one-cycle `load_ir` pulse, and accepts PC redirects from control, including redirects that arrive while a read is in flight.

## Interface
- `RESET_PC`, default 16'h0000: PC value after reset; bit 0 is forced to 0.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `fetch_req` in 1: control requests the next instruction; sampled only in IDLE.
- `pc_load` in 1: redirect the PC to `pc_in`.
- `pc_in` in 16: redirect target (lc3b_word); bit 0 ignored, treated as 0.
- `mem_address` out 16: read address; stable for the whole request.
- `mem_read` out 1: read strobe; held until `mem_resp`.
- `mem_resp` in 1: memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 16: instruction word from memory.
- `ir_word` out 16: registered fetched word; drives the IR `in` input.
- `load_ir` out 1: one-cycle pulse; drives the IR `load` input.
- `pc_out` out 16: current PC, already advanced past the delivered instruction.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, REQ, DELIVER, GAP.
- **IDLE**
  - `mem_read` = 0 and `load_ir` = 0.
  - If `fetch_req` = 1: `addr_q` <= PC (or `pc_in` if `pc_load` is also 1), then go to REQ.
- **REQ**
  - `mem_read` = 1 and `mem_address` = `addr_q`.
  - On `mem_resp` = 1 with no squash pending:
    - `ir_word` <= `mem_rdata`.
    - PC <= `addr_q` + 2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
    - Go to DELIVER.
- **DELIVER**
  - `load_ir` = 1 for exactly this cycle; `ir_word` is stable.
  - Go to IDLE.
- **Squash**
  - Any `pc_load` in REQ sets `squash` and PC <= `pc_in`. `addr_q` and `mem_address` do not change.
  - On `mem_resp` with `squash` set (or with `pc_load` in the same cycle):
    - Discard the word; `ir_word` is unchanged.
    - Clear `squash`; PC = the new target, with no +2.
    - Go to GAP.
- **GAP**
  - `mem_read` = 0 for one cycle; `addr_q` <= PC.
  - Go to REQ. The original `fetch_req` is still honoured, so control does not re-request.
- **`pc_load` in IDLE or DELIVER:** PC <= `pc_in` next edge. In DELIVER this overrides the +2, but the word is still delivered.
- **`pc_load` and `fetch_req` together in IDLE:** the fetch uses `pc_in`, and PC becomes `pc_in` + 2 after delivery.
- `fetch_req` in REQ, DELIVER or GAP is ignored; it is not queued.

## Timing
- Reset values (asynchronous):
  - state = IDLE, PC = `RESET_PC`, `addr_q` = `RESET_PC`, `ir_word` = 16'h0000.
  - `mem_read` = 0, `load_ir` = 0, `busy` = 0, `squash` = 0.
- Reset mid-REQ drops `mem_read` immediately; the outstanding response is never consumed.
- Latency from `fetch_req` sampled (edge 0) to `load_ir`, with `mem_resp` arriving N cycles after `mem_read` rises (N ≥ 0):
  - `mem_read` is high in cycles 1..1+N.
  - `load_ir` is high in cycle 2+N.
  - The IR captures at the end of cycle 2+N.
  - `busy` returns to 0 in cycle 3+N.
- Minimum fetch-to-fetch interval is 3 cycles.
- A squashed fetch adds exactly GAP (1 cycle) plus the new memory latency.
- `mem_read` and `mem_address` never change mid-request. There is always at least one low cycle of `mem_read` between transactions.
- `pc_out` is registered; it updates on the `mem_resp` edge and is therefore valid during DELIVER.

## Test plan
- **Basic fetch.**
  - Stimulus: reset with `RESET_PC`=16'h0000, pulse `fetch_req`; memory returns 16'h1283 after 2 wait cycles.
  - Required: `mem_address`=16'h0000 and `mem_read` high for 3 cycles; `load_ir` pulses 1 cycle with `ir_word`=16'h1283; `pc_out`=16'h0002.
- **Back-to-back fetches.**
  - Stimulus: 3 fetches with zero-wait memory.
  - Required: addresses 0, 2, 4; `load_ir` pulses exactly 3 cycles apart; `mem_read` low ≥ 1 cycle between requests.
- **Redirect in flight.**
  - Stimulus: `pc_load` with `pc_in`=16'h3000 in the first REQ cycle; memory response after 3 cycles.
  - Required:
    - `mem_address` stays 16'h0000 until `mem_resp`.
    - No `load_ir` for that word; one GAP cycle.
    - New request at 16'h3000, then delivery with `pc_out`=16'h3002.
- **Redirect collisions.**
  - `pc_load`(16'h0100) coincident with `mem_resp` → word squashed, refetch from 16'h0100.
  - `pc_load`(16'h0200) during DELIVER → `load_ir` still pulses, and `pc_out`=16'h0200 afterward.
  - `pc_load`(16'h0041) + `fetch_req` in IDLE → fetch from 16'h0040.
- **Wrap.**
  - Stimulus: `RESET_PC`=16'hFFFE, fetch once.
  - Required: `mem_address`=16'hFFFE; after delivery `pc_out`=16'h0000.
- **Reset mid-request.**
  - Stimulus: assert `reset` while in REQ.
  - Required: `mem_read`, `load_ir` and `busy` drop to 0 without waiting for a clock edge; `pc_out`=`RESET_PC`; `ir_word`=16'h0000; a later `fetch_req` fetches from `RESET_PC`.
